// File: rtl/alu_pkg.sv
// Shared ALU opcode encoding, arbiter slot states and default datapath width.
package alu_pkg;

    localparam int ALU_DATA_W = 32;

    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_SUB  = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLL  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_SLT  = 4'b1000,
        ALU_SLTU = 4'b1001,
        ALU_BEQ  = 4'b1010,
        ALU_BNE  = 4'b1011,
        ALU_BGE  = 4'b1100,
        ALU_BGEU = 4'b1101,
        ALU_NOP  = 4'b1111
    } alu_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        FULL = 1'b1
    } arb_state_e;

endpackage

// File: rtl/alu.sv
// Combinational ALU: arithmetic/logic ops produce ALUResult, compare ops produce TakeBranch.
module alu
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH    = ALU_DATA_W,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic [DATA_WIDTH-1:0]    SrcA,
    input  logic [DATA_WIDTH-1:0]    SrcB,
    input  logic [OPCODE_LENGTH-1:0] Operation,
    output logic [DATA_WIDTH-1:0]    ALUResult,
    output logic                     TakeBranch
);

    localparam int SHW = $clog2(DATA_WIDTH);

    logic [SHW-1:0] shamt;
    assign shamt = SrcB[SHW-1:0];

    always_comb begin
        ALUResult  = '0;
        TakeBranch = 1'b0;
        case (Operation)
            ALU_AND:  ALUResult = SrcA & SrcB;
            ALU_OR:   ALUResult = SrcA | SrcB;
            ALU_ADD:  ALUResult = SrcA + SrcB;
            ALU_SUB:  ALUResult = SrcA - SrcB;
            ALU_XOR:  ALUResult = SrcA ^ SrcB;
            ALU_SLL:  ALUResult = SrcA << shamt;
            ALU_SRL:  ALUResult = SrcA >> shamt;
            ALU_SRA:  ALUResult = $signed(SrcA) >>> shamt;
            ALU_SLT:  ALUResult = {{(DATA_WIDTH-1){1'b0}}, $signed(SrcA) < $signed(SrcB)};
            ALU_SLTU: ALUResult = {{(DATA_WIDTH-1){1'b0}}, SrcA < SrcB};
            ALU_BEQ:  TakeBranch = (SrcA == SrcB);
            ALU_BNE:  TakeBranch = (SrcA != SrcB);
            ALU_BGE:  TakeBranch = ($signed(SrcA) >= $signed(SrcB));
            ALU_BGEU: TakeBranch = (SrcA >= SrcB);
            default: begin
                ALUResult  = '0;
                TakeBranch = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_arbiter_rr_pick.sv
// Rotating-base priority encoder: first asserted req at or after base wins (one-hot gnt).
module rr_pick #(
    parameter int N  = 2,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] base,
    output logic [N-1:0]  gnt
);

    logic          found;
    logic [IW-1:0] idx;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            idx = IW'((int'(base) + i) % N);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational alu among NUM_REQ requesters with a single registered response slot.
// Define ALU_ARB_RR_EN for round-robin arbitration; otherwise lowest index wins.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH    = ALU_DATA_W,
    parameter int OPCODE_LENGTH = 4,
    parameter int NUM_REQ       = 2,
    parameter int ID_W          = $clog2(NUM_REQ)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_srca,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_srcb,
    input  logic [NUM_REQ*OPCODE_LENGTH-1:0] req_op,
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic [ID_W-1:0]                  rsp_id,
    output logic [DATA_WIDTH-1:0]            rsp_result,
    output logic                             rsp_branch
);

    arb_state_e state_q, state_d;

    logic                     slot_free;
    logic [NUM_REQ-1:0]       gnt;
    logic [ID_W-1:0]          gnt_id;
    logic [ID_W-1:0]          base;
    logic                     accept;
    logic [DATA_WIDTH-1:0]    alu_a, alu_b, alu_res;
    logic [OPCODE_LENGTH-1:0] alu_op;
    logic                     alu_br;

    // rst_n gates the grant so nothing is offered while reset is held,
    // even though the cleared slot would otherwise read as free.
    assign rsp_valid = (state_q == FULL);
    assign slot_free = rst_n & ((state_q == IDLE) | rsp_ready);

    rr_pick #(.N(NUM_REQ), .IW(ID_W)) u_pick (
        .req  (req_valid & {NUM_REQ{slot_free}}),
        .base (base),
        .gnt  (gnt)
    );

    assign req_ready = gnt;
    assign accept    = |(req_valid & gnt);

`ifdef ALU_ARB_RR_EN
    logic [ID_W-1:0] ptr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr_q <= '0;
        else if (accept)
            ptr_q <= (gnt_id == ID_W'(NUM_REQ-1)) ? '0 : gnt_id + 1'b1;
    end

    assign base = ptr_q;
`else
    assign base = '0;
`endif

    // Idle ALU sees zero operands and the NOP opcode, so its outputs are zero.
    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_op = '1;
        gnt_id = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                alu_a  = req_srca[i*DATA_WIDTH +: DATA_WIDTH];
                alu_b  = req_srcb[i*DATA_WIDTH +: DATA_WIDTH];
                alu_op = req_op[i*OPCODE_LENGTH +: OPCODE_LENGTH];
                gnt_id = ID_W'(i);
            end
        end
    end

    alu #(.DATA_WIDTH(DATA_WIDTH), .OPCODE_LENGTH(OPCODE_LENGTH)) u_alu (
        .SrcA       (alu_a),
        .SrcB       (alu_b),
        .Operation  (alu_op),
        .ALUResult  (alu_res),
        .TakeBranch (alu_br)
    );

    always_comb begin
        state_d = state_q;
        if (accept)
            state_d = FULL;
        else if (state_q == FULL && rsp_ready)
            state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_id     <= '0;
            rsp_result <= '0;
            rsp_branch <= 1'b0;
        end else if (accept) begin
            rsp_id     <= gnt_id;
            rsp_result <= alu_res;
            rsp_branch <= alu_br;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter (2 requesters); expectations follow ALU_ARB_RR_EN.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int DW = 32;
    localparam int OW = 4;
    localparam int NR = 2;
    localparam int IW = 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*DW-1:0]  req_srca;
    logic [NR*DW-1:0]  req_srcb;
    logic [NR*OW-1:0]  req_op;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IW-1:0]     rsp_id;
    logic [DW-1:0]     rsp_result;
    logic              rsp_branch;

    int total = 0;
    int bad   = 0;

    alu_arbiter #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OW), .NUM_REQ(NR), .ID_W(IW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_srca   (req_srca),
        .req_srcb   (req_srcb),
        .req_op     (req_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_branch (rsp_branch)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        req_srca[i*DW +: DW] = a;
        req_srcb[i*DW +: DW] = b;
        req_op[i*OW +: OW]   = op;
    endtask

    // Responses are checked #1 after the rising edge; inputs change on the falling edge.
    task automatic edge_chk(input string tag, input logic exp_v, input logic [31:0] exp_id,
                            input logic [31:0] exp_res, input logic exp_br);
        @(posedge clk);
        #1;
        chk({tag, ".v"},   {31'd0, rsp_valid},  {31'd0, exp_v});
        chk({tag, ".id"},  {31'd0, rsp_id},     exp_id);
        chk({tag, ".res"}, rsp_result,          exp_res);
        chk({tag, ".br"},  {31'd0, rsp_branch}, {31'd0, exp_br});
    endtask

    logic [31:0] exp_ids [4];

    initial begin
`ifdef ALU_ARB_RR_EN
        exp_ids = '{32'd0, 32'd1, 32'd0, 32'd1};
`else
        exp_ids = '{32'd0, 32'd0, 32'd0, 32'd0};
`endif
        rst_n     = 1'b0;
        req_valid = 2'b01;
        req_srca  = '0;
        req_srcb  = '0;
        req_op    = '0;
        rsp_ready = 1'b1;
        #12;
        chk("rst.ready", {30'd0, req_ready}, 32'd0);
        chk("rst.valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst.res",   rsp_result, 32'd0);
        chk("rst.id",    {31'd0, rsp_id}, 32'd0);
        chk("rst.br",    {31'd0, rsp_branch}, 32'd0);

        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = 2'b00;

        // single add
        @(negedge clk);
        set_req(0, 32'd5, 32'd7, ALU_ADD);
        req_valid = 2'b01;
        #1 chk("add.ready", {30'd0, req_ready}, 32'd1);
        edge_chk("add", 1'b1, 32'd0, 32'd12, 1'b0);
        @(negedge clk);
        req_valid = 2'b00;
        edge_chk("drain0", 1'b0, 32'd0, 32'd12, 1'b0);

        // branch compare on requester 1, equal then unequal
        @(negedge clk);
        set_req(1, 32'd3, 32'd3, ALU_BEQ);
        req_valid = 2'b10;
        #1 chk("beq.ready", {30'd0, req_ready}, 32'd2);
        edge_chk("beq1", 1'b1, 32'd1, 32'd0, 1'b1);
        @(negedge clk);
        set_req(1, 32'd3, 32'd4, ALU_BEQ);
        edge_chk("beq0", 1'b1, 32'd1, 32'd0, 1'b0);
        @(negedge clk);
        set_req(1, 32'd3, 32'd4, ALU_BNE);
        edge_chk("bne", 1'b1, 32'd1, 32'd0, 1'b1);
        @(negedge clk);
        set_req(1, 32'd5, 32'd5, 4'b1110);
        edge_chk("undef", 1'b1, 32'd1, 32'd0, 1'b0);
        @(negedge clk);
        req_valid = 2'b00;
        edge_chk("drain1", 1'b0, 32'd1, 32'd0, 1'b0);

        // contention: pointer is back at 0 after the last grant to requester 1
        @(negedge clk);
        set_req(0, 32'd1, 32'd1, ALU_ADD);
        set_req(1, 32'd10, 32'd10, ALU_ADD);
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++)
            edge_chk($sformatf("cont%0d", k), 1'b1, exp_ids[k],
                     (exp_ids[k] == 32'd0) ? 32'd2 : 32'd20, 1'b0);
        @(negedge clk);
        req_valid = 2'b00;
        edge_chk("drain2", 1'b0, exp_ids[3], (exp_ids[3] == 32'd0) ? 32'd2 : 32'd20, 1'b0);

        // backpressure: SUB 2-5 held for 3 cycles, then next request on release
        @(negedge clk);
        set_req(0, 32'd2, 32'd5, ALU_SUB);
        req_valid = 2'b01;
        edge_chk("sub", 1'b1, 32'd0, 32'hFFFFFFFD, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            rsp_ready = 1'b0;
            set_req(0, 32'd100, 32'd1, ALU_ADD);
            #1 chk($sformatf("bp%0d.ready", k), {30'd0, req_ready}, 32'd0);
            edge_chk($sformatf("bp%0d", k), 1'b1, 32'd0, 32'hFFFFFFFD, 1'b0);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        #1 chk("bp.release", {30'd0, req_ready}, 32'd1);
        edge_chk("bp.next", 1'b1, 32'd0, 32'd101, 1'b0);
        @(negedge clk);
        req_valid = 2'b00;
        edge_chk("drain3", 1'b0, 32'd0, 32'd101, 1'b0);

        // reset while FULL; with RR the pointer sits at 1 before the reset
        @(negedge clk);
        set_req(0, 32'hFFFFFFFF, 32'd1, ALU_SLT);
        req_valid = 2'b01;
        edge_chk("slt", 1'b1, 32'd0, 32'd1, 1'b0);
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 2'b11;
        #2 rst_n = 1'b0;
        #1;
        chk("mid.valid", {31'd0, rsp_valid}, 32'd0);
        chk("mid.res",   rsp_result, 32'd0);
        chk("mid.ready", {30'd0, req_ready}, 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        set_req(0, 32'hFF, 32'h0F, ALU_AND);
        set_req(1, 32'hF0, 32'h0F, ALU_OR);
        #1 chk("post.ready", {30'd0, req_ready}, 32'd1);
        edge_chk("post", 1'b1, 32'd0, 32'h0F, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

- Shares the single combinational `alu` datapath among `NUM_REQ` requesters (e.g. execute stage, branch-compare unit, address-generation helper).
- Each requester presents operands and a 4-bit opcode over a valid/ready handshake.
- The arbiter grants one request per cycle, drives the ALU, and registers `ALUResult`/`TakeBranch` into a response slot tagged with the requester index.
- It sits between the requesters and the one `alu` instance, which it instantiates.

## Interface
- `DATA_WIDTH`, 32, operand/result width, passed to `alu`.
- `OPCODE_LENGTH`, 4, opcode width, passed to `alu`.
- `NUM_REQ`, 2, number of requesters; legal range 2..4.
- `ID_W`, `$clog2(NUM_REQ)`, width of the requester tag.
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ  per-requester request valid.
- `req_ready`  out  NUM_REQ  per-requester accept; one-hot or zero.
- `req_srca`  in  NUM_REQ*DATA_WIDTH  packed operand A; slice i belongs to requester i.
- `req_srcb`  in  NUM_REQ*DATA_WIDTH  packed operand B.
- `req_op`  in  NUM_REQ*OPCODE_LENGTH  packed opcodes.
- `rsp_valid`  out  1  response slot occupied.
- `rsp_ready`  in  1  consumer accepts response.
- `rsp_id`  out  ID_W  index of the requester that owns the response.
- `rsp_result`  out  DATA_WIDTH  registered `ALUResult`.
- `rsp_branch`  out  1  registered `TakeBranch`.

## Operation
- **States:**
  - `IDLE`: response slot empty.
  - `FULL`: `rsp_valid`=1.
- **Slot free condition:**
  - `slot_free` = (state==IDLE) | (rsp_valid & rsp_ready).
  - The slot is freed and refilled in the same cycle, giving full throughput.
- **Grant:**
  - When `slot_free` and any `req_valid`, exactly one index g is granted and `req_ready[g]`=1.
  - Otherwise `req_ready`=0.
- **ALU drive:**
  - `alu` inputs are `req_srca/srcb/op` slice g.
  - With no grant the inputs are 0 and opcode 4'b1111, giving result 0 and branch 0.
- **Accept** (`req_valid[g] & req_ready[g]`): at the edge, `rsp_result`←ALUResult, `rsp_branch`←TakeBranch, `rsp_id`←g, state→FULL.
- **Drain without refill** (`rsp_valid & rsp_ready` and no accept): state→IDLE.
- **Holding a response:** response fields are held stable while `rsp_valid & !rsp_ready`.
- **Requester rules:**
  - A requester must hold valid and payload stable until accepted.
  - Dropping valid early is illegal and is not checked.
- **Opcodes:**
  - Passed through unchanged.
  - Undefined opcodes (4'b1110, 4'b1111) yield result 0 and branch 0.
  - Branch-only opcodes (4'b1010–4'b1101) yield result 0 with a meaningful `rsp_branch`.
- **Reset values:** `req_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_result`=0, `rsp_branch`=0, state=IDLE, priority pointer=0.
- **Reset mid-operation:** an in-flight response is discarded without being delivered.

## Timing
- **Latency:** request accepted at edge T → `rsp_valid`=1 after T; first consumable at edge T+1.
- **Critical path:** the ALU path is combinational from the request mux to the response register, one cycle in total.
- **Throughput:** 1 transaction/cycle when `rsp_ready` is held high.
- **Backpressure:** `rsp_ready`=0 with FULL → `req_ready`=0 the same cycle (combinational from `rsp_ready`).
- **Simultaneous drain+accept:** the new response overwrites the slot at the same edge; no bubble.

## Configuration
- **`ALU_ARB_RR_EN` defined:**
  - Round-robin arbitration.
  - Search begins at the pointer; pointer ← (g+1) mod NUM_REQ on each accept.
  - The pointer is unchanged when nothing is accepted.
- **`ALU_ARB_RR_EN` undefined:**
  - Fixed priority; lowest asserted index wins.
  - The pointer register is not built.

## Structure
- **Package `alu_pkg`:**
  - Opcode enum: `ALU_AND`=4'b0000 … `ALU_SLTU`=4'b1001, `ALU_BEQ`=4'b1010, `ALU_BNE`, `ALU_BGE`, `ALU_BGEU`=4'b1101, `ALU_NOP`=4'b1111.
  - `ALU_DATA_W`=32.
- **Sub-module `rr_pick`:**
  - Rotating-base priority encoder: inputs `req`, `base`; output one-hot `gnt`.
  - With base tied to 0 it is fixed priority.
- **Instances:** `alu_arbiter` instantiates `rr_pick` and `alu`.

## Test plan
- **Single add:** req0 valid, A=5, B=7, op 4'b0010, `rsp_ready`=1 → `req_ready[0]`=1 at T; `rsp_valid`=1 at T+1 with result 12, id 0, branch 0.
- **Branch compare:** req1 A=3, B=3, op 4'b1010 → result 0, branch 1, id 1; repeat with B=4 → branch 0.
- **Contention, RR:** both valid continuously for 4 grants → ids 0,1,0,1.
- **Contention, fixed priority** (macro undefined) → ids 0,0,0,0; requester 1 starves.
- **Backpressure:** `rsp_ready`=0 for 3 cycles after accepting a SUB (A=2, B=5) → `rsp_result`=32'hFFFFFFFD held stable and `req_ready`=0 throughout; on release, the next request is accepted the same cycle.
- **Reset mid-op:** `rst_n` low while FULL holding SLT (A=-1, B=1, result 1) → `rsp_valid`, `rsp_result`, `req_ready` all 0 immediately, asynchronously; after release, the pointer is 0 and the first grant is to req0.
